// File: rtl/pc_redirect_unit.sv
// ---------------------------------------------------------------------------
// pc_redirect_unit
//   Fetch-PC owner for a 3-stage IF/ID/EX RISC-V pipeline. Resolves taken
//   branches, jal and jalr from the EX stage, redirects the fetch PC, flushes
//   the wrong-path IF/ID instructions and keeps a saturating redirect count.
//
// Optional feature macro: MISALIGN_TRAP_EN
//   defined   : a taken redirect whose target has bit 1 set is not loaded;
//               the unit enters a sticky TRAP state (only reset exits).
//   undefined : target[1:0] is forced to 00 before loading; trap_o tied 0.
//
// Ports
//   clk             in   system clock, rising edge
//   reset           in   asynchronous, active-low reset
//   stall_i         in   hazard stall: holds PC, blocks EX resolution
//   ex_valid_i      in   EX stage holds a valid instruction
//   ex_pc_i         in   PC of the EX instruction
//   branch_i        in   EX instruction is a conditional branch
//   jal_i           in   EX instruction is jal
//   jalr_i          in   EX instruction is jalr
//   alu_result_i    in   bit0 = branch taken; full word = jalr base+imm
//   imm_i           in   sign-extended branch/jal offset
//   pc_o            out  current fetch address (registered)
//   fetch_valid_o   out  fetch address valid this cycle (registered)
//   flush_o         out  kill IF/ID contents this cycle (combinational)
//   redirect_cnt_o  out  saturating count of taken redirects (registered)
//   trap_o          out  sticky misaligned-target trap (registered)
// ---------------------------------------------------------------------------
module pc_redirect_unit #(
  parameter logic [31:0] RESET_PC = 32'h0040_0000,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall_i,
  input  logic             ex_valid_i,
  input  logic [31:0]      ex_pc_i,
  input  logic             branch_i,
  input  logic             jal_i,
  input  logic             jalr_i,
  input  logic [31:0]      alu_result_i,
  input  logic [31:0]      imm_i,
  output logic [31:0]      pc_o,
  output logic             fetch_valid_o,
  output logic             flush_o,
  output logic [CNT_W-1:0] redirect_cnt_o,
  output logic             trap_o
);

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] PC_STEP   = XLEN'(4);
  localparam logic [XLEN-1:0] JALR_MASK = 32'hFFFF_FFFE;

`ifdef MISALIGN_TRAP_EN
  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_TRAP = 2'd2
  } state_e;
`else
  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1
  } state_e;
`endif

  state_e           state_q, state_d;
  logic [XLEN-1:0]  pc_q, pc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fetch_valid_q, fetch_valid_d;
  logic             trap_q, trap_d;

  logic             take;
  logic             misalign;
  logic [XLEN-1:0]  target_raw;
  logic [XLEN-1:0]  target;

  // EX resolution: only a running, unstalled pipeline with a valid EX op redirects
  always_comb begin
    take       = 1'b0;
    target_raw = '0;
    if ((state_q == ST_RUN) && ex_valid_i && !stall_i) begin
      take = jalr_i | jal_i | (branch_i & alu_result_i[0]);
    end
    // jalr has priority over the pc-relative forms
    if (jalr_i) begin
      target_raw = alu_result_i & JALR_MASK;
    end else begin
      target_raw = ex_pc_i + imm_i;
    end
  end

  // Misalignment handling: trap on target[1], or silently word-align
`ifdef MISALIGN_TRAP_EN
  always_comb begin
    misalign = take & target_raw[1];
    target   = target_raw;
  end
`else
  always_comb begin
    misalign = 1'b0;
    target   = {target_raw[XLEN-1:2], 2'b00};
  end
`endif

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_BOOT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_BOOT: state_d = ST_RUN;
      ST_RUN: begin
        state_d = ST_RUN;
`ifdef MISALIGN_TRAP_EN
        if (misalign) begin
          state_d = ST_TRAP;
        end
`endif
      end
`ifdef MISALIGN_TRAP_EN
      ST_TRAP: state_d = ST_TRAP;
`endif
      default: state_d = ST_BOOT;
    endcase
  end

  // Datapath / output next values
  always_comb begin
    pc_d          = pc_q;
    cnt_d         = cnt_q;
    fetch_valid_d = (state_d == ST_RUN);
`ifdef MISALIGN_TRAP_EN
    trap_d        = trap_q | (state_d == ST_TRAP);
`else
    trap_d        = 1'b0;
`endif
    flush_o       = take;

    if (state_q == ST_RUN) begin
      if (take) begin
        // A trapping redirect leaves PC and counter untouched
        if (!misalign) begin
          pc_d  = target;
          cnt_d = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
        end
      end else if (!stall_i) begin
        pc_d = pc_q + PC_STEP;
      end
    end
  end

  // Registered datapath and outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q          <= RESET_PC;
      cnt_q         <= '0;
      fetch_valid_q <= 1'b0;
      trap_q        <= 1'b0;
    end else begin
      pc_q          <= pc_d;
      cnt_q         <= cnt_d;
      fetch_valid_q <= fetch_valid_d;
      trap_q        <= trap_d;
    end
  end

  assign pc_o           = pc_q;
  assign fetch_valid_o  = fetch_valid_q;
  assign redirect_cnt_o = cnt_q;
  assign trap_o         = trap_q;

endmodule

// File: tb/tb_pc_redirect_unit.sv
module tb_pc_redirect_unit;

  localparam int unsigned CNT_W = 16;
  localparam logic [31:0] RST_PC = 32'h0040_0000;

  logic             clk;
  logic             reset;
  logic             stall_i;
  logic             ex_valid_i;
  logic [31:0]      ex_pc_i;
  logic             branch_i;
  logic             jal_i;
  logic             jalr_i;
  logic [31:0]      alu_result_i;
  logic [31:0]      imm_i;
  logic [31:0]      pc_o;
  logic             fetch_valid_o;
  logic             flush_o;
  logic [CNT_W-1:0] redirect_cnt_o;
  logic             trap_o;

  int n_checks = 0;
  int n_fail   = 0;

  pc_redirect_unit #(.RESET_PC(RST_PC), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .reset          (reset),
    .stall_i        (stall_i),
    .ex_valid_i     (ex_valid_i),
    .ex_pc_i        (ex_pc_i),
    .branch_i       (branch_i),
    .jal_i          (jal_i),
    .jalr_i         (jalr_i),
    .alu_result_i   (alu_result_i),
    .imm_i          (imm_i),
    .pc_o           (pc_o),
    .fetch_valid_o  (fetch_valid_o),
    .flush_o        (flush_o),
    .redirect_cnt_o (redirect_cnt_o),
    .trap_o         (trap_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    stall_i      = 1'b0;
    ex_valid_i   = 1'b0;
    ex_pc_i      = '0;
    branch_i     = 1'b0;
    jal_i        = 1'b0;
    jalr_i       = 1'b0;
    alu_result_i = '0;
    imm_i        = '0;
  endtask

  // Reset, release, and advance to the first RUN cycle (pc = RST_PC)
  task automatic do_reset();
    clear_inputs();
    reset = 1'b0;
    step();
    reset = 1'b1;
    step();
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b0;
    step();
    step();
    n_checks++; if (pc_o !== RST_PC) begin n_fail++; $display("FAIL reset_pc got %h exp %h", pc_o, RST_PC); end
    n_checks++; if (fetch_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", fetch_valid_o); end
    n_checks++; if (redirect_cnt_o !== '0) begin n_fail++; $display("FAIL reset_cnt got %h exp 0", redirect_cnt_o); end
    n_checks++; if (trap_o !== 1'b0) begin n_fail++; $display("FAIL reset_trap got %b exp 0", trap_o); end
    ex_valid_i = 1'b1; jal_i = 1'b1; #1;
    n_checks++; if (flush_o !== 1'b0) begin n_fail++; $display("FAIL reset_flush got %b exp 0", flush_o); end
    clear_inputs();
    reset = 1'b1;
    #1;
    n_checks++; if (fetch_valid_o !== 1'b0 || pc_o !== RST_PC) begin n_fail++; $display("FAIL boot_cycle1 got pc %h v %b exp %h v 0", pc_o, fetch_valid_o, RST_PC); end
    step();
    n_checks++; if (fetch_valid_o !== 1'b1 || pc_o !== RST_PC) begin n_fail++; $display("FAIL boot_cycle2 got pc %h v %b exp %h v 1", pc_o, fetch_valid_o, RST_PC); end
    step();
    n_checks++; if (pc_o !== 32'h0040_0004) begin n_fail++; $display("FAIL boot_cycle3 got %h exp 00400004", pc_o); end
  endtask

  task automatic test_branch();
    // Taken branch backwards by 8
    ex_valid_i = 1'b1; branch_i = 1'b1; alu_result_i = 32'h1;
    ex_pc_i = 32'h0040_0010; imm_i = 32'hFFFF_FFF8; #1;
    n_checks++; if (flush_o !== 1'b1) begin n_fail++; $display("FAIL br_taken_flush got %b exp 1", flush_o); end
    step();
    n_checks++; if (pc_o !== 32'h0040_0008) begin n_fail++; $display("FAIL br_taken_pc got %h exp 00400008", pc_o); end
    n_checks++; if (redirect_cnt_o !== 16'd1) begin n_fail++; $display("FAIL br_taken_cnt got %0d exp 1", redirect_cnt_o); end
    // Not-taken branch
    alu_result_i = 32'h0; #1;
    n_checks++; if (flush_o !== 1'b0) begin n_fail++; $display("FAIL br_nt_flush got %b exp 0", flush_o); end
    step();
    n_checks++; if (pc_o !== 32'h0040_000C || redirect_cnt_o !== 16'd1) begin n_fail++; $display("FAIL br_nt_pc got %h cnt %0d exp 0040000c cnt 1", pc_o, redirect_cnt_o); end
    // Invalid EX slot: jal ignored
    clear_inputs(); jal_i = 1'b1; imm_i = 32'h100; #1;
    n_checks++; if (flush_o !== 1'b0) begin n_fail++; $display("FAIL exinv_flush got %b exp 0", flush_o); end
    step();
    n_checks++; if (pc_o !== 32'h0040_0010) begin n_fail++; $display("FAIL exinv_pc got %h exp 00400010", pc_o); end
    clear_inputs();
  endtask

  task automatic test_jalr();
    ex_valid_i = 1'b1; jalr_i = 1'b1; alu_result_i = 32'h0040_0101; #1;
    n_checks++; if (flush_o !== 1'b1) begin n_fail++; $display("FAIL jalr_flush got %b exp 1", flush_o); end
    step();
    n_checks++; if (pc_o !== 32'h0040_0100 || redirect_cnt_o !== 16'd2) begin n_fail++; $display("FAIL jalr_pc got %h cnt %0d exp 00400100 cnt 2", pc_o, redirect_cnt_o); end
    // jalr and jal together: jalr target wins
    jal_i = 1'b1; alu_result_i = 32'h0040_0201; ex_pc_i = 32'h0040_0000; imm_i = 32'h0000_0100;
    step();
    n_checks++; if (pc_o !== 32'h0040_0200 || redirect_cnt_o !== 16'd3) begin n_fail++; $display("FAIL jalr_prio got %h cnt %0d exp 00400200 cnt 3", pc_o, redirect_cnt_o); end
    clear_inputs();
  endtask

  task automatic test_stall();
    logic [31:0] held;
    held = pc_o;
    stall_i = 1'b1; ex_valid_i = 1'b1; branch_i = 1'b1; alu_result_i = 32'h1;
    ex_pc_i = 32'h0040_0100; imm_i = 32'h40;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++; if (flush_o !== 1'b0) begin n_fail++; $display("FAIL stall_flush[%0d] got %b exp 0", i, flush_o); end
      step();
      n_checks++; if (pc_o !== held) begin n_fail++; $display("FAIL stall_pc[%0d] got %h exp %h", i, pc_o, held); end
    end
    stall_i = 1'b0; #1;
    n_checks++; if (flush_o !== 1'b1) begin n_fail++; $display("FAIL unstall_flush got %b exp 1", flush_o); end
    step();
    n_checks++; if (pc_o !== 32'h0040_0140 || redirect_cnt_o !== 16'd4) begin n_fail++; $display("FAIL unstall_pc got %h cnt %0d exp 00400140 cnt 4", pc_o, redirect_cnt_o); end
    clear_inputs();
  endtask

  task automatic test_misalign();
    do_reset();
    ex_valid_i = 1'b1; jal_i = 1'b1; ex_pc_i = 32'h0040_0000; imm_i = 32'h6; #1;
    n_checks++; if (flush_o !== 1'b1) begin n_fail++; $display("FAIL mis_flush got %b exp 1", flush_o); end
    step();
`ifdef MISALIGN_TRAP_EN
    n_checks++; if (trap_o !== 1'b1 || fetch_valid_o !== 1'b0) begin n_fail++; $display("FAIL mis_trap got t %b v %b exp t 1 v 0", trap_o, fetch_valid_o); end
    n_checks++; if (pc_o !== RST_PC || redirect_cnt_o !== 16'd0) begin n_fail++; $display("FAIL mis_hold got %h cnt %0d exp %h cnt 0", pc_o, redirect_cnt_o, RST_PC); end
    clear_inputs(); step(); step();
    n_checks++; if (trap_o !== 1'b1 || pc_o !== RST_PC || fetch_valid_o !== 1'b0) begin n_fail++; $display("FAIL mis_sticky got t %b pc %h v %b", trap_o, pc_o, fetch_valid_o); end
`else
    n_checks++; if (pc_o !== 32'h0040_0004 || redirect_cnt_o !== 16'd1) begin n_fail++; $display("FAIL mis_align got %h cnt %0d exp 00400004 cnt 1", pc_o, redirect_cnt_o); end
    n_checks++; if (trap_o !== 1'b0 || fetch_valid_o !== 1'b1) begin n_fail++; $display("FAIL mis_notrap got t %b v %b exp t 0 v 1", trap_o, fetch_valid_o); end
`endif
    clear_inputs();
    do_reset();
  endtask

  task automatic test_wrap();
    ex_valid_i = 1'b1; jalr_i = 1'b1; alu_result_i = 32'hFFFF_FFFC;
    step();
    n_checks++; if (pc_o !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_setup got %h exp fffffffc", pc_o); end
    clear_inputs();
    step();
    n_checks++; if (pc_o !== 32'h0000_0000) begin n_fail++; $display("FAIL wrap_pc got %h exp 00000000", pc_o); end
    // pc-relative target wraps modulo 2^32
    ex_valid_i = 1'b1; jal_i = 1'b1; ex_pc_i = 32'hFFFF_FFF0; imm_i = 32'h20;
    step();
    n_checks++; if (pc_o !== 32'h0000_0010) begin n_fail++; $display("FAIL wrap_target got %h exp 00000010", pc_o); end
    clear_inputs();
  endtask

  task automatic test_back_to_back_saturate();
    ex_valid_i = 1'b1; jal_i = 1'b1; ex_pc_i = 32'h0000_1000; imm_i = 32'h0;
    for (int i = 0; i < (1 << CNT_W) + 2; i++) step();
    n_checks++; if (redirect_cnt_o !== {CNT_W{1'b1}}) begin n_fail++; $display("FAIL sat_cnt got %h exp ffff", redirect_cnt_o); end
    n_checks++; if (pc_o !== 32'h0000_1000 || flush_o !== 1'b1) begin n_fail++; $display("FAIL sat_pc got %h f %b exp 00001000 f 1", pc_o, flush_o); end
    clear_inputs();
  endtask

  task automatic test_reset_mid_redirect();
    ex_valid_i = 1'b1; jal_i = 1'b1; ex_pc_i = 32'h0000_2000; imm_i = 32'h10;
    #2;
    reset = 1'b0;
    #1;
    n_checks++; if (pc_o !== RST_PC || redirect_cnt_o !== '0 || flush_o !== 1'b0 || fetch_valid_o !== 1'b0) begin
      n_fail++; $display("FAIL midreset got pc %h cnt %h f %b v %b", pc_o, redirect_cnt_o, flush_o, fetch_valid_o);
    end
    step();
    n_checks++; if (pc_o !== RST_PC) begin n_fail++; $display("FAIL midreset_hold got %h exp %h", pc_o, RST_PC); end
    clear_inputs();
    reset = 1'b1;
    step();
    step();
    n_checks++; if (pc_o !== 32'h0040_0004 || fetch_valid_o !== 1'b1) begin n_fail++; $display("FAIL midreset_resume got %h v %b exp 00400004 v 1", pc_o, fetch_valid_o); end
  endtask

  initial begin
    test_reset();
    test_branch();
    test_jalr();
    test_stall();
    test_misalign();
    test_wrap();
    test_back_to_back_saturate();
    test_reset_mid_redirect();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_redirect_unit.md
Name: pc_redirect_unit

Overview:
- Program-counter stage directly downstream of the 32-bit ALU. It owns the fetch PC register and consumes the ALU's branch-compare result (BEQ/BNE/BLT/BGE produce 1 when taken) and its jalr target sum.
- Computes next PC, flushes wrong-path IF/ID instructions on redirect, and counts redirects.
- Sits between the EX stage and instruction memory in a 3-stage IF/ID/EX RISC-V pipeline.

Parameters:
RESET_PC, 32'h0040_0000, fetch address loaded on reset
CNT_W, 16, width of saturating redirect counter

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
stall_i  input  1  hazard stall; holds PC and freezes EX resolution
ex_valid_i  input  1  EX stage holds a valid instruction
ex_pc_i  input  32  PC of the EX instruction
branch_i  input  1  EX instruction is a conditional branch
jal_i  input  1  EX instruction is jal
jalr_i  input  1  EX instruction is jalr
alu_result_i  input  32  ALU result: bit0 = branch taken; full word = jalr base+imm
imm_i  input  32  sign-extended branch/jal offset
pc_o  output  32  current fetch address (registered)
fetch_valid_o  output  1  fetch address is valid this cycle
flush_o  output  1  kill IF/ID contents this cycle (combinational)
redirect_cnt_o  output  CNT_W  count of taken redirects, saturating
trap_o  output  1  misaligned-target trap, sticky (see Optional Feature)

Behaviour:
- Reset (reset==0, async): pc_o=RESET_PC, state=BOOT, fetch_valid_o=0, redirect_cnt_o=0, trap_o=0. flush_o=0 while in reset.
- States:
  - BOOT: one cycle after reset release; fetch_valid_o=0; PC held; -> RUN unconditionally.
  - RUN: fetch_valid_o=1.
  - TRAP: exists only with the optional feature.
- take = ex_valid_i & !stall_i & (jalr_i | jal_i | (branch_i & alu_result_i[0])).
- Target priority: jalr_i > jal_i > branch_i (flags are one-hot; priority defined for robustness).
  - jalr: target = alu_result_i & 32'hFFFF_FFFE.
  - jal/branch: target = ex_pc_i + imm_i, modulo 2^32 (wraps, no overflow flag).
- Next PC in RUN, at each rising edge:
  - stall_i=1: pc_o held; take forced 0. The redirect resolves when the stall releases.
  - take=1: pc_o <= target.
  - otherwise: pc_o <= pc_o + 4. Wraps 32'hFFFF_FFFC -> 0.
- flush_o = take, same cycle as the resolution. Latency: target appears on pc_o one cycle after take.
- redirect_cnt_o increments by 1 on each take edge and saturates at all-ones.
- Branch with alu_result_i[0]=0: no redirect, no flush, sequential PC.
- ex_valid_i=0: all control inputs ignored.
- Reset asserted mid-redirect: reset wins immediately; no partial update.

Optional Feature:
Macro: MISALIGN_TRAP_EN.
- Defined:
  - If take=1 and target[1]==1, pc_o is not updated; flush_o=1 that cycle; next state TRAP; redirect_cnt_o not incremented.
  - TRAP: trap_o=1, fetch_valid_o=0, pc_o frozen. Only reset exits.
- Undefined:
  - target[1:0] forced to 00 before loading; trap_o tied 0; no TRAP state.

Test Plan:
1. Release reset -> cycle 1: pc_o=0x0040_0000, fetch_valid_o=0. Cycle 2: valid=1. Cycle 3: pc_o=0x0040_0004.
2. branch_i=1, alu_result_i=1, ex_pc_i=0x0040_0010, imm_i=-8 -> flush_o=1 same cycle, next pc_o=0x0040_0008, redirect_cnt_o=1. Repeat with alu_result_i=0 -> no flush, pc_o+4.
3. jalr_i=1, alu_result_i=0x0040_0101 -> next pc_o=0x0040_0100. Also assert jal_i together: jalr target still wins.
4. stall_i=1 with a taken branch pending for 3 cycles -> pc_o constant, flush_o=0. On release -> redirect and flush in that cycle.
5. pc_o=0xFFFF_FFFC, no take -> next pc_o=0x0000_0000. Drive 2^CNT_W+2 takes -> redirect_cnt_o stays all-ones.
6. MISALIGN_TRAP_EN defined, jal target 0x0040_0006 -> flush_o=1, trap_o=1 next cycle, fetch_valid_o=0, pc_o held. Undefined: pc_o=0x0040_0004.
